eth_rx_byte_packer: RTL

ETH_RX_BYTE_PACKER -- requirements
Module: eth_rx_byte_packer

---
 rtl/eth_rx_byte_packer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_byte_packer.sv
// eth_rx_byte_packer
//   Packs the MAC receive byte stream into little-endian AXI-Stream words.
//   Byte k of a word lands in tdata[8k+7:8k] and sets tkeep[k]. A word is
//   emitted when its top lane fills or when the frame ends. The output is a
//   single register, so the byte side is throttled only when that register
//   is full and the sink is stalling.
//
//   Optional feature macro: ETH_RX_PACKER_OVERSIZE_EN
//     When defined, a frame that reaches eth_mtu_p bytes without tlast is
//     cut short. Its last word is marked tlast/tuser, and the rest of the
//     frame is swallowed up to its tlast byte.
//
// Parameters
//   data_width_p  output word width in bits (32 or 64)
//   eth_mtu_p     maximum frame length in bytes (multiple of data_width_p/8)
//
// Ports
//   clk_i              clock, all state on rising edge
//   reset_i            synchronous active-high reset
//   rx_byte_tdata_i    frame byte from MAC
//   rx_byte_tvalid_i   byte valid
//   rx_byte_tready_o   byte accepted when high with tvalid
//   rx_byte_tlast_i    final byte of frame
//   rx_byte_tuser_i    MAC error flag for the frame
//   rx_axis_tdata_o    packed word
//   rx_axis_tkeep_o    byte enables, contiguous from bit 0
//   rx_axis_tvalid_o   word valid
//   rx_axis_tready_i   sink ready
//   rx_axis_tlast_o    last word of frame
//   rx_axis_tuser_o    frame error, meaningful on the last word only
//
// FSM (present only with ETH_RX_PACKER_OVERSIZE_EN)
//   state  | meaning
//   S_PASS | packing bytes into words
//   S_DROP | frame exceeded eth_mtu_p; discarding bytes until tlast

module eth_rx_byte_packer #(
  parameter int data_width_p = 64,
  parameter int eth_mtu_p    = 2048
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [7:0]                rx_byte_tdata_i,
  input  logic                      rx_byte_tvalid_i,
  output logic                      rx_byte_tready_o,
  input  logic                      rx_byte_tlast_i,
  input  logic                      rx_byte_tuser_i,
  output logic [data_width_p-1:0]   rx_axis_tdata_o,
  output logic [data_width_p/8-1:0] rx_axis_tkeep_o,
  output logic                      rx_axis_tvalid_o,
  input  logic                      rx_axis_tready_i,
  output logic                      rx_axis_tlast_o,
  output logic                      rx_axis_tuser_o
);

  localparam int bytes_p  = data_width_p / 8;
  localparam int lane_w_p = $clog2(bytes_p);

  if ((data_width_p != 32 && data_width_p != 64) || (eth_mtu_p % bytes_p) != 0) begin : g_bad_params
    $error("eth_rx_byte_packer: illegal data_width_p/eth_mtu_p combination");
  end

  logic [data_width_p-1:0] acc_data_r;
  logic [lane_w_p-1:0]     lane_r;
  logic                    sticky_r;

  logic [data_width_p-1:0] out_data_r;
  logic [bytes_p-1:0]      out_keep_r;
  logic                    out_valid_r;
  logic                    out_last_r;
  logic                    out_user_r;

  logic                    drop_mode;
  logic                    oversize_hit;
  logic                    byte_accept;
  logic                    pass_accept;
  logic                    lane_full;
  logic                    word_last;
  logic                    word_load;
  logic [data_width_p-1:0] word_data;
  logic [bytes_p-1:0]      word_keep;

  // While dropping, bytes are discarded, so the output register never gates them.
  assign rx_byte_tready_o = drop_mode | ~out_valid_r | rx_axis_tready_i;
  assign byte_accept      = rx_byte_tvalid_i & rx_byte_tready_o;
  assign pass_accept      = byte_accept & ~drop_mode;
  assign lane_full        = (lane_r == lane_w_p'(bytes_p - 1));
  assign word_last        = rx_byte_tlast_i | oversize_hit;
  assign word_load        = pass_accept & (lane_full | word_last);

  // Upper lanes of the accumulator are always zero, so the merged word needs
  // no masking beyond inserting the current byte.
  always_comb begin
    word_data = acc_data_r;
    word_data[lane_r*8 +: 8] = rx_byte_tdata_i;
    word_keep = '0;
    for (int k = 0; k < bytes_p; k++) begin
      word_keep[k] = (lane_w_p'(k) <= lane_r);
    end
  end

`ifdef ETH_RX_PACKER_OVERSIZE_EN
  localparam int cnt_w_p = $clog2(eth_mtu_p + 1);

  typedef enum logic {S_PASS, S_DROP} state_t;

  state_t             state_r;
  state_t             state_n;
  logic [cnt_w_p-1:0] byte_cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_PASS;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      S_PASS: if (pass_accept && oversize_hit) state_n = S_DROP;
      S_DROP: if (byte_accept && rx_byte_tlast_i) state_n = S_PASS;
      default: state_n = S_PASS;
    endcase
  end

  always_comb begin
    drop_mode = (state_r == S_DROP);
  end

  // byte_cnt_r holds the number of bytes already accepted in this frame, so
  // the byte that would be number eth_mtu_p sees eth_mtu_p-1 here.
  assign oversize_hit = (byte_cnt_r == cnt_w_p'(eth_mtu_p - 1)) & ~rx_byte_tlast_i;

  // Cleared on the truncating word, so it is already zero on leaving S_DROP.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_cnt_r <= '0;
    end else if (pass_accept) begin
      if (word_last) byte_cnt_r <= '0;
      else           byte_cnt_r <= byte_cnt_r + cnt_w_p'(1);
    end
  end
`else
  assign drop_mode    = 1'b0;
  assign oversize_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_data_r  <= '0;
      lane_r      <= '0;
      sticky_r    <= 1'b0;
      out_data_r  <= '0;
      out_keep_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_user_r  <= 1'b0;
    end else begin
      if (pass_accept) begin
        if (word_load) begin
          acc_data_r <= '0;
          lane_r     <= '0;
        end else begin
          acc_data_r <= word_data;
          lane_r     <= lane_r + lane_w_p'(1);
        end
        // A truncated frame also clears here; S_DROP never sets it again.
        if (word_last)            sticky_r <= 1'b0;
        else if (rx_byte_tuser_i) sticky_r <= 1'b1;
      end

      // A load is only possible when the register is empty or transferring
      // this cycle, so stalled output contents are never disturbed.
      if (word_load) begin
        out_data_r  <= word_data;
        out_keep_r  <= word_keep;
        out_valid_r <= 1'b1;
        out_last_r  <= word_last;
        out_user_r  <= word_last & (sticky_r | rx_byte_tuser_i | oversize_hit);
      end else if (rx_axis_tready_i) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign rx_axis_tdata_o  = out_data_r;
  assign rx_axis_tkeep_o  = out_keep_r;
  assign rx_axis_tvalid_o = out_valid_r;
  assign rx_axis_tlast_o  = out_last_r;
  assign rx_axis_tuser_o  = out_user_r;

endmodule
